// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
//
// Control unit for a UART transmitter. Accepts one payload word through a
// valid/ready handshake and frames it as START / DATA (LSB first) / STOP on
// an idle-high serial line. Produces the bit-period tick and the state
// strobes used by the downstream bit counter and shift logic.
//
// Parameters
//   DATA_WIDTH         payload bits per frame
//   CLKS_PER_BIT       clock cycles per serial bit (>= 2)
//   STOP_BITS          number of stop bits (1 or 2)
//   BIT_COUNTER_WIDTH  width of o_bit_index (2**W >= DATA_WIDTH)
//
// Ports
//   i_clock           system clock, rising edge
//   i_reset           synchronous active-high reset, highest priority
//   i_tx_valid        request to send i_tx_data
//   i_tx_data         payload, captured only on a handshake
//   o_tx_ready        high only in IDLE
//   o_serial          serial TX line, idle-high
//   o_state_is_START  high throughout START
//   o_state_is_DATA   high throughout DATA
//   o_equal           baud tick, last clock of every bit period (non-IDLE)
//   o_bit_index       index of the data bit currently on o_serial
//   o_busy            high in START, DATA and STOP (inverse of o_tx_ready)
//   o_done            one-cycle pulse on the final clock of the last stop bit
//
// Every output is decoded from registered state only; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module uart_tx_controller #(
  parameter int DATA_WIDTH        = 8,
  parameter int CLKS_PER_BIT      = 16,
  parameter int STOP_BITS         = 1,
  parameter int BIT_COUNTER_WIDTH = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_tx_valid,
  input  logic [DATA_WIDTH-1:0]        i_tx_data,
  output logic                         o_tx_ready,
  output logic                         o_serial,
  output logic                         o_state_is_START,
  output logic                         o_state_is_DATA,
  output logic                         o_equal,
  output logic [BIT_COUNTER_WIDTH-1:0] o_bit_index,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]            BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] IDX_LAST  = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);
  // One bit is enough to count up to two stop bits.
  localparam logic                         STOP_LAST = 1'(STOP_BITS - 1);

  // Binary encoding leaves four spare codes; all of them fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } state_t;

  state_t                         state_p0;
  state_t                         state_nx;
  logic [BAUD_W-1:0]              baud_cnt_p0;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_idx_p0;
  logic                           stop_cnt_p0;
  logic [DATA_WIDTH-1:0]          tx_data_p0;

  logic                           active;
  logic                           tick;
  logic                           idx_last;
  logic                           stop_last;
  logic                           handshake;
  logic [DATA_WIDTH-1:0]          data_shift;

  // Decodes of registered state shared by the next-state and output logic.
  always_comb begin
    active = (state_p0 == ST_START) || (state_p0 == ST_DATA) || (state_p0 == ST_STOP);
  end

  assign tick       = active && (baud_cnt_p0 == BAUD_LAST);
  assign idx_last   = (bit_idx_p0 == IDX_LAST);
  assign stop_last  = (stop_cnt_p0 == STOP_LAST);
  assign handshake  = i_tx_valid && (state_p0 == ST_IDLE);
  assign data_shift = tx_data_p0 >> bit_idx_p0;

  // ---- state register -------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nx;
    end
  end

  // ---- next-state logic -----------------------------------------------------
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      ST_IDLE:  if (i_tx_valid)            state_nx = ST_START;
      ST_START: if (tick)                  state_nx = ST_DATA;
      ST_DATA:  if (tick && idx_last)      state_nx = ST_STOP;
      ST_STOP:  if (tick && stop_last)     state_nx = ST_IDLE;
      default:                             state_nx = ST_IDLE;
    endcase
  end

  // ---- baud, bit-index, stop counters and payload register ------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      baud_cnt_p0 <= '0;
      bit_idx_p0  <= '0;
      stop_cnt_p0 <= 1'b0;
      tx_data_p0  <= '0;
    end else begin
      // Held at zero in IDLE so the first START cycle starts a full period.
      if (!active || tick) begin
        baud_cnt_p0 <= '0;
      end else begin
        baud_cnt_p0 <= baud_cnt_p0 + 1'b1;
      end

      // Index only moves inside DATA and is cleared on the way out, so
      // START always hands over with index 0.
      if (state_p0 != ST_DATA) begin
        bit_idx_p0 <= '0;
      end else if (tick) begin
        bit_idx_p0 <= idx_last ? '0 : bit_idx_p0 + 1'b1;
      end

      if (state_p0 != ST_STOP) begin
        stop_cnt_p0 <= 1'b0;
      end else if (tick) begin
        stop_cnt_p0 <= stop_last ? 1'b0 : stop_cnt_p0 + 1'b1;
      end

      if (handshake) begin
        tx_data_p0 <= i_tx_data;
      end
    end
  end

  // ---- output decode --------------------------------------------------------
  always_comb begin
    o_tx_ready       = 1'b0;
    o_serial         = 1'b1;
    o_state_is_START = 1'b0;
    o_state_is_DATA  = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        o_tx_ready = 1'b1;
      end
      ST_START: begin
        o_serial         = 1'b0;
        o_state_is_START = 1'b1;
      end
      ST_DATA: begin
        o_serial        = data_shift[0];
        o_state_is_DATA = 1'b1;
      end
      ST_STOP: begin
        o_serial = 1'b1;
      end
      default: begin
        o_serial = 1'b1;
      end
    endcase
    o_busy      = !o_tx_ready;
    o_equal     = tick;
    o_done      = (state_p0 == ST_STOP) && tick && stop_last;
    o_bit_index = bit_idx_p0;
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_controller
//
// Two controller instances share clock and reset:
//   inst 0: DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 (40-cycle frame)
//   inst 1: DATA_WIDTH=8, CLKS_PER_BIT=2, STOP_BITS=2 (22-cycle frame)
// A reference model decides from the frame-length arithmetic when each
// instance is free, and pushes every accepted payload into a queue. A monitor
// records each frame the DUT emits and, on o_done, pops the expected payload
// and compares the whole per-cycle waveform against the frame rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_controller;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tx_valid;
  logic [7:0] tx_data_a;
  logic [7:0] tx_data_b;
  logic [1:0] rdy, ser, st_start, st_data, eq, bsy, done;
  logic [2:0] idx_a, idx_b;

  uart_tx_controller #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .BIT_COUNTER_WIDTH(3)
  ) dut_a (
    .i_clock(clk), .i_reset(rst), .i_tx_valid(tx_valid[0]), .i_tx_data(tx_data_a),
    .o_tx_ready(rdy[0]), .o_serial(ser[0]), .o_state_is_START(st_start[0]),
    .o_state_is_DATA(st_data[0]), .o_equal(eq[0]), .o_bit_index(idx_a),
    .o_busy(bsy[0]), .o_done(done[0])
  );

  uart_tx_controller #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(2), .STOP_BITS(2), .BIT_COUNTER_WIDTH(3)
  ) dut_b (
    .i_clock(clk), .i_reset(rst), .i_tx_valid(tx_valid[1]), .i_tx_data(tx_data_b),
    .o_tx_ready(rdy[1]), .o_serial(ser[1]), .o_state_is_START(st_start[1]),
    .o_state_is_DATA(st_data[1]), .o_equal(eq[1]), .o_bit_index(idx_b),
    .o_busy(bsy[1]), .o_done(done[1])
  );

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  int         bfrom[2]  = '{1, 1};
  int         buntil[2] = '{0, 0};
  bit         abort_exp[2] = '{1'b0, 1'b0};
  bit         in_frame[2]  = '{1'b0, 1'b0};
  int         flen_cap[2]  = '{0, 0};
  int         start_cap[2] = '{0, 0};
  logic [6:0] cap[2][64];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int cpb(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int stopb(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int flen(input int k);
    return (1 + DW + stopb(k)) * cpb(k);
  endfunction

  // Expected {serial, tick, START, DATA, bit_index} at offset t of a frame.
  function automatic logic [6:0] exp_code(input int k, input logic [7:0] d, input int t);
    int         c;
    int         p;
    logic [7:0] sh;
    logic       s;
    logic [2:0] ix;
    c  = cpb(k);
    p  = t / c;
    sh = (p >= 1) ? (d >> (p - 1)) : 8'h00;
    s  = (p == 0) ? 1'b0 : ((p <= DW) ? sh[0] : 1'b1);
    ix = (p >= 1 && p <= DW) ? 3'(p - 1) : 3'd0;
    return {s, ((t % c) == c - 1), (p == 0), (p >= 1 && p <= DW), ix};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d, input int hold);
    if (k == 0) tx_data_a = d;
    else        tx_data_b = d;
    tx_valid[k] = 1'b1;
    tick(hold);
    tx_valid[k] = 1'b0;
  endtask

  task automatic check_frame(input int k);
    frame_t f;
    int     nbad;
    int     first;
    int     at;
    chk($sformatf("frame_expected%0d", k), 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    f = exp_q.pop_front();
    chk($sformatf("frame_inst%0d", k), 64'(f.inst), 64'(k));
    chk($sformatf("frame_start%0d", k), 64'(start_cap[k]), 64'(f.start));
    chk($sformatf("frame_len%0d", k), 64'(flen_cap[k]), 64'(flen(k)));
    nbad  = 0;
    first = -1;
    for (int t = 0; t < flen_cap[k] && t < 64; t++) begin
      if (cap[k][t] !== exp_code(k, f.data, t)) begin
        nbad++;
        if (first < 0) first = t;
      end
    end
    at = (first < 0) ? 0 : first;
    chk($sformatf("frame%0d_data%02h_bad%0d_t%0d", k, f.data, nbad, at),
        64'(cap[k][at]), 64'(exp_code(k, f.data, at)));
  endtask

  // Reference model: an instance is busy for flen() cycles starting the cycle
  // after it accepts; reset truncates the busy window at the reset cycle.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit     busy_m;
      frame_t f;
      busy_m = (cyc >= bfrom[k]) && (cyc <= buntil[k]);
      if (rst) begin
        if (busy_m) begin
          buntil[k]    = cyc;
          abort_exp[k] = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (tx_valid[k] && !busy_m) begin
        f.inst  = k;
        f.data  = (k == 0) ? tx_data_a : tx_data_b;
        f.start = cyc + 1;
        exp_q.push_back(f);
        bfrom[k]  = cyc + 1;
        buntil[k] = cyc + flen(k);
      end
    end
  end

  // Monitor: per-cycle idle/ready checks and frame capture.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] ix;
        bit         exp_rdy;
        ix      = (k == 0) ? idx_a : idx_b;
        exp_rdy = !((cyc >= bfrom[k]) && (cyc <= buntil[k]));
        chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(exp_rdy));
        chk($sformatf("busy%0d", k), 64'(bsy[k]), 64'(!rdy[k]));
        if (!bsy[k]) begin
          if (in_frame[k]) begin
            chk($sformatf("abort%0d", k), 64'(abort_exp[k]), 64'd1);
            in_frame[k] = 1'b0;
          end
          abort_exp[k] = 1'b0;
          chk($sformatf("idle%0d", k),
              64'({ser[k], eq[k], st_start[k], st_data[k], done[k], ix}), 64'h80);
        end else begin
          if (!in_frame[k]) begin
            in_frame[k]  = 1'b1;
            flen_cap[k]  = 0;
            start_cap[k] = cyc;
          end
          if (flen_cap[k] < 64)
            cap[k][flen_cap[k]] = {ser[k], eq[k], st_start[k], st_data[k], ix};
          flen_cap[k]++;
          if (done[k]) begin
            check_frame(k);
            in_frame[k] = 1'b0;
          end else if (flen_cap[k] == 64) begin
            chk($sformatf("overlong%0d", k), 64'(flen_cap[k]), 64'(flen(k)));
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    tx_valid  = 2'b00;
    tx_data_a = 8'h00;
    tx_data_b = 8'h00;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_serial", 64'(ser[0]), 64'd1);
    chk("rst_ready", 64'(rdy[0]), 64'd1);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_idx", 64'(idx_a), 64'd0);
    tick(20);

    // single 0xA5 frame
    send(0, 8'hA5, 1);
    tick(45);

    // back-to-back 0x00 then 0xFF with valid held across o_done
    tx_data_a   = 8'h00;
    tx_valid[0] = 1'b1;
    tick(2);
    tx_data_a = 8'hFF;
    tick(40);
    tx_valid[0] = 1'b0;
    tick(45);

    // valid with 0x3C during DATA of a 0x81 frame is ignored
    send(0, 8'h81, 1);
    tick(9);
    tx_data_a   = 8'h3C;
    tx_valid[0] = 1'b1;
    tick(10);
    chk("ignore_ready", 64'(rdy[0]), 64'd0);
    tx_valid[0] = 1'b0;
    tick(40);

    // reset while bit 3 is on the line, then a clean 0x55 frame
    send(0, 8'hC3, 1);
    tick(17);
    chk("pre_rst_idx", 64'(idx_a), 64'd3);
    chk("pre_rst_data", 64'(st_data[0]), 64'd1);
    rst = 1'b1;
    tick(1);
    chk("post_rst_serial", 64'(ser[0]), 64'd1);
    chk("post_rst_ready", 64'(rdy[0]), 64'd1);
    chk("post_rst_idx", 64'(idx_a), 64'd0);
    chk("post_rst_data", 64'(st_data[0]), 64'd0);
    rst = 1'b0;
    tick(1);
    send(0, 8'h55, 1);
    tick(45);

    // two stop bits, two clocks per bit
    send(1, 8'h01, 1);
    tick(30);

    // randomized traffic, one instance active at a time
    for (int i = 0; i < 24; i++) begin
      int         k;
      logic [7:0] d;
      k = int'($urandom_range(0, 1));
      d = 8'($urandom);
      if (k == 0) tx_data_a = d;
      else        tx_data_b = d;
      tx_valid[k] = 1'b1;
      tick(int'($urandom_range(1, 50)));
      if ($urandom_range(0, 1) == 1) begin
        if (k == 0) tx_data_a = 8'($urandom);
        else        tx_data_b = 8'($urandom);
        tick(int'($urandom_range(1, 30)));
      end
      tx_valid[k] = 1'b0;
      tick(int'($urandom_range(45, 50)));
    end

    tick(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("no_open_frame", 64'({in_frame[0], in_frame[1]}), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
Control unit for the UART transmit datapath. It accepts a parallel byte through a valid/ready handshake and generates the bit-period timing (baud tick). It sequences the IDLE/START/DATA/STOP frame and tracks the bit index. It drives the serial line plus the state and tick strobes consumed by the transmit bit counter and shift logic.

Parameters:
DATA_WIDTH, 8, payload bits per frame, sent LSB first.
CLKS_PER_BIT, 16, i_clock cycles per serial bit; legal values are 2 or more.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
BIT_COUNTER_WIDTH, 3, width of o_bit_index; must satisfy 2^BIT_COUNTER_WIDTH >= DATA_WIDTH.

Ports:
i_clock  in  1  single system clock; all logic on its rising edge.
i_reset  in  1  synchronous, active-high reset.
i_tx_valid  in  1  request to send i_tx_data.
i_tx_data  in  DATA_WIDTH  byte to send; sampled only on handshake.
o_tx_ready  out  1  controller can accept a byte (high only in IDLE).
o_serial  out  1  UART TX line; idle-high.
o_state_is_START  out  1  high throughout START state.
o_state_is_DATA  out  1  high throughout DATA state.
o_equal  out  1  baud tick; one-cycle pulse on the last clock of every bit period, in any non-IDLE state.
o_bit_index  out  BIT_COUNTER_WIDTH  index of the data bit currently on o_serial.
o_busy  out  1  high in START, DATA and STOP.
o_done  out  1  one-cycle pulse on the final clock of the last stop bit.

Behaviour:
- Reset: when i_reset is high at a rising edge, the next state is IDLE. After that edge: o_serial=1, o_tx_ready=1, o_busy=0, o_done=0, o_equal=0, o_state_is_START=0, o_state_is_DATA=0, o_bit_index=0. The baud counter, stop counter and data register are cleared.
- Reset mid-frame aborts immediately. o_serial returns high on the next edge, with no partial stop bit. i_reset has priority over every other input.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Handshake: a transfer occurs when i_tx_valid and o_tx_ready are both high at a rising edge. i_tx_data is latched into an internal register and the state moves to START. i_tx_valid while busy is ignored; nothing is queued.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 in non-IDLE states and is held at 0 in IDLE.
  - o_equal is high when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- FSM:
  - IDLE -> START on handshake.
  - START: o_serial=0 for CLKS_PER_BIT cycles. On o_equal, go to DATA with o_bit_index=0.
  - DATA: o_serial = data[o_bit_index]. On o_equal, if o_bit_index == DATA_WIDTH-1, go to STOP and clear o_bit_index. Otherwise increment o_bit_index. There is no wrap-around past DATA_WIDTH-1.
  - STOP: o_serial=1 for STOP_BITS*CLKS_PER_BIT cycles. A stop-bit counter advances on each o_equal. On the o_equal of the last stop bit, o_done=1 and the state moves to IDLE.
  - Undefined state encodings recover to IDLE.
- Latency and throughput:
  - The first START cycle is the cycle after the handshake edge.
  - The frame lasts exactly (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
  - o_tx_ready is low during the o_done cycle and rises the cycle after, so back-to-back frames have exactly one idle-high cycle between them.
- Simultaneous events: i_tx_valid high during the o_done cycle is not accepted; it is accepted on the next cycle if still asserted.
- o_busy equals NOT o_tx_ready at all times outside reset.

Test Plan:
- Reset/idle (CLKS_PER_BIT=4): hold i_reset for 3 cycles, then release -> o_serial=1, o_tx_ready=1, o_busy=0, o_equal never pulses, for 20 cycles.
- Single frame (CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1): send 0xA5 -> o_serial reads 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. The frame spans 40 cycles. o_done pulses on cycle 40 and o_tx_ready returns on cycle 41. o_equal pulses 10 times.
- Back-to-back: keep i_tx_valid high with 0x00 then 0xFF -> the second START begins exactly 2 cycles after the o_done cycle of the first frame (one idle-high cycle between frames). o_done pulses once per frame.
- Ignore while busy: assert i_tx_valid with 0x3C during the DATA state of a 0x81 frame -> the 0x81 bit pattern is unchanged, o_tx_ready stays low, and no extra frame follows unless valid is still high after o_done.
- Reset mid-frame: assert i_reset at o_bit_index=3 in DATA -> the next cycle shows o_serial=1, IDLE, o_bit_index=0. A subsequent 0x55 frame is bit-exact.
- Two stop bits (STOP_BITS=2, CLKS_PER_BIT=2): send 0x01 -> o_serial is high for 4 cycles after the data bits and the frame length is 22 cycles. o_state_is_START is high for 2 cycles; o_state_is_DATA is high for 16 cycles.
